// File: rtl/clk_gen.sv
// Programmable clock divider with glitch-free stop, edge pulses and optional rise counter.
// Define CLK_GEN_CYCLE_COUNT_EN to add the cycle_cnt output and its counter.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_STOPPED | idle: clk_out, phase counter and pulses held at 0
// ST_RUN     | toggling clk_out every HALF_PERIOD clk cycles
module clk_gen #(
  parameter int HALF_PERIOD = 50,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             running
`ifdef CLK_GEN_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt
`endif
);

  localparam int              PH_W    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUN     = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PH_W-1:0] r_phase, w_phase_nxt;
  logic            r_clk_out, w_clk_out_nxt;
  logic            r_rise, w_rise_nxt;
  logic            r_fall, w_fall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_STOPPED;
      r_phase   <= '0;
      r_clk_out <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_clk_out <= w_clk_out_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = '0;
    w_clk_out_nxt = r_clk_out;
    w_rise_nxt    = 1'b0;
    w_fall_nxt    = 1'b0;
    case (r_state)
      ST_STOPPED: begin
        w_clk_out_nxt = 1'b0;
        // The start edge is also the first counting edge of the low phase.
        if (en) begin
          w_state_nxt = ST_RUN;
          if (r_phase == PH_LAST) begin
            w_clk_out_nxt = 1'b1;
            w_rise_nxt    = 1'b1;
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
      end
      ST_RUN: begin
        // Stopping only from the low phase keeps every high phase full length.
        if (!en && !r_clk_out) begin
          w_state_nxt   = ST_STOPPED;
          w_clk_out_nxt = 1'b0;
        end else if (r_phase == PH_LAST) begin
          w_clk_out_nxt = ~r_clk_out;
          w_rise_nxt    = ~r_clk_out;
          w_fall_nxt    = r_clk_out;
        end else begin
          w_phase_nxt = r_phase + PH_W'(1);
        end
      end
      default: begin
        w_state_nxt   = ST_STOPPED;
        w_clk_out_nxt = 1'b0;
      end
    endcase
  end

  assign clk_out    = r_clk_out;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign running    = (r_state == ST_RUN);

`ifdef CLK_GEN_CYCLE_COUNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
    end else if (w_rise_nxt) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_clk_gen.sv
// Directed bench for clk_gen: HALF_PERIOD=50 (CNT_W=2) and HALF_PERIOD=1 instances.
// Counter checks are active only when CLK_GEN_CYCLE_COUNT_EN is defined.
module tb_clk_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en50 = 1'b1;
  logic en1 = 1'b1;

  logic co50, rp50, fp50, run50;
  logic co1, rp1, fp1, run1;
  logic [1:0]  cnt50;
  logic [15:0] cnt1;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  always #5 clk = ~clk;

  clk_gen #(.HALF_PERIOD(50), .CNT_W(2)) dut50 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en50),
    .clk_out    (co50),
    .rise_pulse (rp50),
    .fall_pulse (fp50),
    .running    (run50)
`ifdef CLK_GEN_CYCLE_COUNT_EN
    ,
    .cycle_cnt  (cnt50)
`endif
  );

  clk_gen #(.HALF_PERIOD(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en1),
    .clk_out    (co1),
    .rise_pulse (rp1),
    .fall_pulse (fp1),
    .running    (run1)
`ifdef CLK_GEN_CYCLE_COUNT_EN
    ,
    .cycle_cnt  (cnt1)
`endif
  );

`ifndef CLK_GEN_CYCLE_COUNT_EN
  assign cnt50 = '0;
  assign cnt1  = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  // {clk_out, rise_pulse, fall_pulse, running}
  function automatic logic [3:0] st50();
    return {co50, rp50, fp50, run50};
  endfunction

  function automatic logic [3:0] st1();
    return {co1, rp1, fp1, run1};
  endfunction

  initial begin
    #2;
    chk("reset_hp50", 32'(st50()), 32'h0);
    chk("reset_hp1",  32'(st1()),  32'h0);
`ifdef CLK_GEN_CYCLE_COUNT_EN
    chk("reset_cnt50", 32'(cnt50), 32'h0);
`endif

    // Start, first edges, stop from high phase, restart
    do_reset();
    tick();
    chk("hp50_e1",  32'(st50()), 32'b0001);
    chk("hp1_e1",   32'(st1()),  32'b1101);
    tick();
    chk("hp1_e2",   32'(st1()),  32'b0011);
    tick();
    chk("hp1_e3",   32'(st1()),  32'b1101);
    tick();
    chk("hp1_e4",   32'(st1()),  32'b0011);
    run_to(49);
    chk("hp50_e49", 32'(st50()), 32'b0001);
    tick();
    chk("hp50_rise50", 32'(st50()), 32'b1101);
`ifdef CLK_GEN_CYCLE_COUNT_EN
    chk("cnt_e50", 32'(cnt50), 32'd1);
`endif
    tick();
    chk("hp50_e51", 32'(st50()), 32'b1001);
    run_to(99);
    chk("hp50_e99", 32'(st50()), 32'b1001);
    tick();
    chk("hp50_fall100", 32'(st50()), 32'b0011);
    tick();
    chk("hp50_e101", 32'(st50()), 32'b0001);
    run_to(149);
    chk("hp50_e149", 32'(st50()), 32'b0001);
    tick();
    chk("hp50_rise150", 32'(st50()), 32'b1101);
`ifdef CLK_GEN_CYCLE_COUNT_EN
    chk("cnt_e150", 32'(cnt50), 32'd2);
`endif
    run_to(160);
    en50 = 1'b0;
    run_to(199);
    chk("stop_hi_e199", 32'(st50()), 32'b1001);
    tick();
    chk("stop_hi_fall200", 32'(st50()), 32'b0011);
    tick();
    chk("stop_hi_e201", 32'(st50()), 32'b0000);
    for (int i = 202; i <= 210; i++) begin
      tick();
      chk("stopped_idle", 32'(st50()), 32'b0000);
    end
`ifdef CLK_GEN_CYCLE_COUNT_EN
    chk("cnt_hold", 32'(cnt50), 32'd2);
`endif
    en50 = 1'b1;
    tick();
    chk("restart_e211", 32'(st50()), 32'b0001);
    run_to(259);
    chk("restart_e259", 32'(st50()), 32'b0001);
    tick();
    chk("restart_rise260", 32'(st50()), 32'b1101);
`ifdef CLK_GEN_CYCLE_COUNT_EN
    chk("cnt_restart", 32'(cnt50), 32'd3);
`endif

    // Stop requested during the low phase
    do_reset();
    run_to(120);
    chk("stop_lo_e120", 32'(st50()), 32'b0001);
    en50 = 1'b0;
    tick();
    chk("stop_lo_e121", 32'(st50()), 32'b0000);
    for (int i = 122; i <= 170; i++) begin
      tick();
      chk("stop_lo_idle", 32'(st50()), 32'b0000);
    end

    // Ten output periods, then asynchronous reset during the high phase
    en50 = 1'b1;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      run_to(50 + 100 * (k - 1));
      chk("period_rise", 32'(st50()), 32'b1101);
`ifdef CLK_GEN_CYCLE_COUNT_EN
      chk("cnt_seq", 32'(cnt50), 32'(k % 4));
`endif
    end
`ifdef CLK_GEN_CYCLE_COUNT_EN
    chk("cnt_final", 32'(cnt50), 32'd2);
`endif
    run_to(960);
    chk("pre_async_hi", 32'(st50()), 32'b1001);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hp50", 32'(st50()), 32'b0000);
    chk("async_rst_hp1",  32'(st1()),  32'b0000);
`ifdef CLK_GEN_CYCLE_COUNT_EN
    chk("async_rst_cnt50", 32'(cnt50), 32'd0);
    chk("async_rst_cnt1",  32'(cnt1),  32'd0);
`endif
    #2;
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_gen.md
CLK_GEN -- requirements
Module: clk_gen

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 50: number of clk cycles per output half-period; legal range 1 to 65535.
REQ-002 SHALL have parameter CNT_W, default 16: width of the cycle_cnt output.
REQ-003 SHALL have port clk, input, 1 bit: single reference clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: run request for the generator.
REQ-006 SHALL have port clk_out, output, 1 bit: generated clock, 50% duty cycle, period 2*HALF_PERIOD clk cycles.
REQ-007 SHALL have port rise_pulse, output, 1 bit: high for exactly one clk cycle, in the cycle clk_out becomes 1.
REQ-008 SHALL have port fall_pulse, output, 1 bit: high for exactly one clk cycle, in the cycle clk_out becomes 0.
REQ-009 SHALL have port running, output, 1 bit: 1 while the generator is toggling.
REQ-010 SHALL have port cycle_cnt, output, CNT_W bits: count of clk_out rising edges (present only with the macro in REQ-024).

Function
REQ-011 SHALL hold an internal phase counter, width clog2(HALF_PERIOD), minimum 1 bit.
REQ-012 While running, each clk edge SHALL do one of two things:
- counter == HALF_PERIOD-1: clear the counter and invert clk_out.
- otherwise: increment the counter.
REQ-013 Starting from reset with en=1, the first rising edge of clk_out SHALL occur on the HALF_PERIOD-th clk rising edge after rst_n deasserts.
REQ-014 SHALL have exactly two states, STOPPED and RUN.
- STOPPED -> RUN: on a clk edge with en=1; that edge also counts as the first counting edge.
- RUN -> STOPPED: only while clk_out=0.
REQ-015 When en=0 while RUN and clk_out=0, the next edge SHALL enter STOPPED with counter cleared and clk_out held at 0.
REQ-016 When en=0 while RUN and clk_out=1, the generator SHALL complete the full high phase, drive clk_out low at the normal edge, then enter STOPPED. No high phase may be truncated (glitch-free stop).
REQ-017 While STOPPED, clk_out, the counter, rise_pulse and fall_pulse SHALL be 0.
REQ-018 rise_pulse and fall_pulse SHALL be registered and change on the same edge as clk_out.
REQ-019 running SHALL be 1 exactly in the RUN state.
REQ-020 With HALF_PERIOD=1, clk_out SHALL toggle on every clk edge, giving a divide-by-2 clock.
REQ-021 cycle_cnt SHALL increment on every rise_pulse cycle, wrap modulo 2^CNT_W, and hold its value while STOPPED.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately, without waiting for a clk edge, force STOPPED, counter=0, clk_out=0, rise_pulse=0, fall_pulse=0, running=0 and cycle_cnt=0.
REQ-023 Reset asserted mid-phase (including while clk_out=1) SHALL take effect asynchronously. The first edge after release SHALL be treated as the STOPPED->RUN edge if en=1.

Configuration
REQ-024 Macro CLK_GEN_CYCLE_COUNT_EN:
- Defined: the cycle_cnt port and its counter SHALL be present.
- Undefined: cycle_cnt and its logic SHALL be absent from the port list; all other behaviour SHALL be unchanged.

Verification
REQ-025 HALF_PERIOD=50, en=1, release reset -> clk_out rises at clk edge 50, falls at edge 100, rises at edge 150; rise_pulse is high for 1 cycle at edges 50 and 150.
REQ-026 HALF_PERIOD=50, en dropped at edge 120 (clk_out=0) -> STOPPED at edge 121, clk_out stays 0, running=0.
REQ-027 HALF_PERIOD=50, en dropped at edge 160 (clk_out=1) -> clk_out falls at edge 200, then STOPPED; no further rising edges.
REQ-028 HALF_PERIOD=1, en=1 -> clk_out toggles every clk edge; rise_pulse and fall_pulse alternate each cycle.
REQ-029 HALF_PERIOD=50, macro defined, CNT_W=2, run for 10 output periods -> cycle_cnt sequence 1,2,3,0,1,...; ends at 2.
REQ-030 Assert rst_n=0 asynchronously while clk_out=1 -> clk_out, cycle_cnt and running go 0 before the next clk edge.
